// File: rtl/nubus_timeout_if.sv
// NuBus signal bundle for the bus timeout monitor: sampled bus inputs
// plus the registered /ACK and /TM drive values and their output enables.
interface nubus_timeout_if;
  logic        nub_startn;
  logic        nub_ackn;
  logic [31:0] nub_adn;
  logic        nub_tm1n;
  logic        nub_tm0n;
  logic        nub_ackn_o;
  logic        nub_ackoe;
  logic        nub_tm1n_o;
  logic        nub_tm0n_o;
  logic        nub_tmoe;

  // Monitor side: samples the bus and drives the timeout response.
  modport slave (
    input  nub_startn, nub_ackn, nub_adn, nub_tm1n, nub_tm0n,
    output nub_ackn_o, nub_ackoe, nub_tm1n_o, nub_tm0n_o, nub_tmoe
  );

  // Bus side: owns /START, /ACK, /AD, /TM and observes the response.
  modport master (
    output nub_startn, nub_ackn, nub_adn, nub_tm1n, nub_tm0n,
    input  nub_ackn_o, nub_ackoe, nub_tm1n_o, nub_tm0n_o, nub_tmoe
  );
endinterface

// File: rtl/nubus_timeout.sv
// NuBus bus timeout monitor. Watches for address cycles that no slave
// acknowledges within TIMEOUT clocks, then terminates the transaction with a
// one-clock /ACK carrying bus-timeout status, and records the offending
// address, direction and a saturating timeout count for software.
module nubus_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic            nub_clkn,
  input  logic            nub_resetn,
  nubus_timeout_if.slave  bus,
  input  logic            enable,
  input  logic            irq_clr,
  output logic            to_irq,
  output logic [31:0]     to_addr,
  output logic            to_write,
  output logic [7:0]      to_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Counter value seen at the edge where the timeout fires (start edge is E0).
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_shadow_addr;
  logic        r_shadow_write;
  logic        r_drive;
  logic        r_to_irq;
  logic [31:0] r_to_addr;
  logic        r_to_write;
  logic [7:0]  r_to_count;

  logic w_addr_cycle;
  logic w_slave_ack;
  logic w_expire;
  logic w_latch;
  logic w_fire;

  // Attention cycles (/START and /ACK both low) are deliberately not address cycles.
  assign w_addr_cycle = ~bus.nub_startn & bus.nub_ackn;
  assign w_slave_ack  = ~bus.nub_ackn;
  assign w_expire     = (r_cnt == LP_LAST);

  // Next-state logic; abort beats slave ack beats a restart beats expiry.
  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && w_addr_cycle) begin
          w_next  = ST_WAIT;
          w_latch = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          w_next = ST_IDLE;
        end else if (w_slave_ack) begin
          w_next = ST_IDLE;
        end else if (w_addr_cycle) begin
          w_latch = 1'b1;
        end else if (w_expire) begin
          w_next = ST_ACK;
          w_fire = 1'b1;
        end
      end
      ST_ACK: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register, wait counter and shadow copy of the pending start.
  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 8'd0;
      r_shadow_addr  <= 32'd0;
      r_shadow_write <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_cnt          <= 8'd0;
        r_shadow_addr  <= ~bus.nub_adn;
        r_shadow_write <= ~bus.nub_tm1n;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Bus drive flop: high only during the single ACK clock, cleared async by reset.
  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      r_drive <= 1'b0;
    end else begin
      r_drive <= w_fire;
    end
  end

  // Timeout status capture; a timeout setting the irq wins over irq_clr.
  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      r_to_irq   <= 1'b0;
      r_to_addr  <= 32'd0;
      r_to_write <= 1'b0;
      r_to_count <= 8'd0;
    end else begin
      if (w_fire) begin
        r_to_irq   <= 1'b1;
        r_to_addr  <= r_shadow_addr;
        r_to_write <= r_shadow_write;
        if (r_to_count != 8'hFF) begin
          r_to_count <= r_to_count + 8'd1;
        end
      end else if (irq_clr) begin
        r_to_irq <= 1'b0;
      end
    end
  end

  assign bus.nub_ackoe  = r_drive;
  assign bus.nub_tmoe   = r_drive;
  assign bus.nub_ackn_o = ~r_drive;
  assign bus.nub_tm1n_o = ~r_drive;
  assign bus.nub_tm0n_o = 1'b1;

  assign to_irq   = r_to_irq;
  assign to_addr  = r_to_addr;
  assign to_write = r_to_write;
  assign to_count = r_to_count;

endmodule
